mdu_ctrl: RTL and testbench

Multiply/divide scheduler for the Execute stage. Accepts mult/multu/div/divu/mthi/mtlo issues, captures the result at issue, and holds it back for a fixed latency. Owns the HI/LO registers and generates the busy and stall signals that hold dependent instructions in Decode. Exceptions and interrupts suppress an issue through `cancel`.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_ctrl_if.sv | 31 +++
 rtl/mdu_arith.sv | 44 ++++
 rtl/mdu_ctrl.sv | 104 ++++++++++
 tb/tb_mdu_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state type and op-class predicates.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mt(input logic [2:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle. The E stage (master) drives issue
// information; the MDU (slave) returns busy/stall, HI/LO and its FSM state.
interface mdu_ctrl_if;
    import mdu_pkg::*;

    // start is a one-cycle issue request, accepted at the clock edge only when
    // cancel is low, op is 1..6 and busy is low; there is no back-pressure
    // beyond busy, and the issuer must not raise start while busy is high.
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_state_e  dbg_state;

    modport master (
        output start, op, rs, rt, cancel, d_md_use,
        input  busy, stall, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, rs, rt, cancel, d_md_use,
        output busy, stall, hi, lo, dbg_state
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Result is {hi,lo}; for divides
// hi is the remainder and lo the quotient.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div0
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        result = '0;
        div0   = 1'b0;
        neg_a  = (op == MDU_DIV) & rs[31];
        neg_b  = (op == MDU_DIV) & rt[31];
        mag_a  = neg_a ? -rs : rs;
        mag_b  = neg_b ? -rt : rt;
        // Divisor forced non-zero so the divider never sees 0; div0 discards the result.
        div_b  = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq     = mag_a / div_b;
        ur     = mag_a % div_b;
        case (op)
            MDU_MULT:  result = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
            MDU_MULTU: result = {32'd0, rs} * {32'd0, rt};
            MDU_DIV, MDU_DIVU: begin
                // 0x80000000 / -1 falls out as magnitude 2^31 re-negated to 0x80000000.
                result = {(neg_a ? -ur : ur), ((neg_a ^ neg_b) ? -uq : uq)};
                div0   = (rt == 32'd0);
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide scheduler: latches the result at issue, holds it for a
// fixed latency, then commits it to HI/LO; also owns busy and D-stage stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] arith_res;
    logic        arith_div0;
    logic        busy;
    logic        issue;

    mdu_arith u_arith (
        .op     (bus.op),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .result (arith_res),
        .div0   (arith_div0)
    );

    assign busy  = (cnt_q != '0);
    assign issue = bus.start & ~bus.cancel & ~busy & (is_muldiv(bus.op) | is_mt(bus.op));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (is_muldiv(bus.op)) begin
                        state_d                = ST_RUN;
                        cnt_d                  = is_div(bus.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        {pend_hi_d, pend_lo_d} = arith_res;
                        div0_d                 = arith_div0;
                    end else if (bus.op == MDU_MTHI) begin
                        hi_d = bus.rs;
                    end else begin
                        lo_d = bus.rs;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (!div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.stall     = bus.d_md_use & (busy | (bus.start & ~bus.cancel & is_muldiv(bus.op)));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus a short random
// sequence, with expected {hi,lo} results queued at issue and popped on completion.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mdu_ctrl_if bus ();
    mdu_ctrl_if bus1 ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hilo;

    // Issuing while busy is illegal for the E stage; flag it if the bench ever does.
    always @(posedge clk) begin
        if (!reset && bus.start && !bus.cancel && bus.busy) begin
            total_cnt++;
            $display("FAIL start_while_busy: got start=1 with busy=1 expected no issue while busy");
        end
    end

    // ---------------- driver tasks (caller is at a negedge) ----------------
    task automatic drive_idle();
        bus.start = 1'b0; bus.op = MDU_NONE; bus.rs = '0; bus.rt = '0;
        bus.cancel = 1'b0; bus.d_md_use = 1'b0;
        bus1.start = 1'b0; bus1.op = MDU_NONE; bus1.rs = '0; bus1.rt = '0;
        bus1.cancel = 1'b0; bus1.d_md_use = 1'b0;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
        bus.start = 1'b1; bus.op = op; bus.rs = val;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        if (op == MDU_MTHI) model_hilo[63:32] = val;
        else                model_hilo[31:0]  = val;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, output int cycles, output int stall_cycles,
                          output logic issue_stall, output logic early);
        cycles = 0; stall_cycles = 0; early = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b; bus.d_md_use = dmd;
        #1 issue_stall = bus.stall;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        while (bus.busy && cycles < 64) begin
            cycles++;
            if (bus.stall) stall_cycles++;
            if ({bus.hi, bus.lo} !== model_hilo) early = 1'b1;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE); else pass_cnt++;
        bus.start = 1'b1; bus.op = MDU_MULT; bus.d_md_use = 1'b1;
        #1;
        total_cnt++; if (bus.stall !== 1'b1) $display("FAIL reset_stall_comb: got %0b expected 1", bus.stall); else pass_cnt++;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        model_hilo = '0;
        @(negedge clk);
    endtask

    task automatic test_mt_and_mult();
        int cyc, stc; logic ist, early;
        do_mt(MDU_MTHI, 32'hAAAA_0000);
        total_cnt++; if (bus.hi !== 32'hAAAA_0000) $display("FAIL mthi_value: got %h expected aaaa0000", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy: got %0b expected 0", bus.busy); else pass_cnt++;
        do_mt(MDU_MTLO, 32'h0000_BBBB);
        total_cnt++; if (bus.lo !== 32'h0000_BBBB) $display("FAIL mtlo_value: got %h expected 0000bbbb", bus.lo); else pass_cnt++;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        bus.start = 1'b1; bus.op = MDU_MULT; bus.rs = 32'hFFFF_FFFE; bus.rt = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        total_cnt++; if (bus.dbg_state !== ST_RUN) $display("FAIL mult_state_run: got %0d expected %0d", bus.dbg_state, ST_RUN); else pass_cnt++;
        cyc = 0; early = 1'b0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            if ({bus.hi, bus.lo} !== model_hilo) early = 1'b1;
            @(negedge clk);
        end
        total_cnt++; if (cyc !== 5) $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (early !== 1'b0) $display("FAIL mult_hold_old: got early change expected hold"); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL mult_result: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
        stc = 0; ist = 1'b0;
    endtask

    task automatic test_div();
        logic [2:0]  t_op[3] = '{MDU_DIVU, MDU_DIV, MDU_DIV};
        logic [31:0] t_a[3]  = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] t_b[3]  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [63:0] t_e[3]  = '{{32'd1, 32'd3}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000}};
        int cyc, stc; logic ist, early;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(t_e[i]);
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, cyc, stc, ist, early);
            total_cnt++; if (cyc !== 10) $display("FAIL div%0d_busy_cycles: got %0d expected 10", i, cyc); else pass_cnt++;
            total_cnt++; if (early !== 1'b0) $display("FAIL div%0d_hold_old: got early change expected hold", i); else pass_cnt++;
            model_hilo = exp_q.pop_front();
            total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL div%0d_result: got %h expected %h", i, {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
        end
    endtask

    task automatic test_div0();
        int cyc, stc; logic ist, early;
        do_mt(MDU_MTHI, 32'h11);
        do_mt(MDU_MTLO, 32'h22);
        exp_q.push_back({32'h11, 32'h22});
        run_op(MDU_DIV, 32'd5, 32'd0, 1'b0, cyc, stc, ist, early);
        total_cnt++; if (cyc !== 10) $display("FAIL div0_busy_cycles: got %0d expected 10", cyc); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL div0_unchanged: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
    endtask

    task automatic test_cancel();
        int cyc;
        do_mt(MDU_MTHI, 32'hCAFE_0001);
        do_mt(MDU_MTLO, 32'hCAFE_0002);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MULT; bus.rs = 32'd3; bus.rt = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = MDU_NONE;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL cancel_mult_busy: got %0b expected 0", bus.busy); else pass_cnt++;
        repeat (6) @(negedge clk);
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL cancel_mult_hilo: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MTHI; bus.rs = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = MDU_NONE;
        total_cnt++; if (bus.hi !== 32'hCAFE_0001) $display("FAIL cancel_mthi: got %h expected cafe0001", bus.hi); else pass_cnt++;
        exp_q.push_back({32'd0, 32'd12});
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs = 32'd3; bus.rt = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE; bus.cancel = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        bus.cancel = 1'b0;
        total_cnt++; if (cyc !== 5) $display("FAIL cancel_run_busy_cycles: got %0d expected 5", cyc); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL cancel_run_commit: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
    endtask

    task automatic test_stall();
        int cyc, stc; logic ist, early;
        exp_q.push_back({32'd0, 32'd10});
        run_op(MDU_MULT, 32'd2, 32'd5, 1'b1, cyc, stc, ist, early);
        total_cnt++; if (ist !== 1'b1) $display("FAIL stall_issue_cycle: got %0b expected 1", ist); else pass_cnt++;
        total_cnt++; if (stc !== 5) $display("FAIL stall_busy_cycles: got %0d expected 5", stc); else pass_cnt++;
        total_cnt++; if (bus.stall !== 1'b0) $display("FAIL stall_after_done: got %0b expected 0", bus.stall); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL stall_mult_result: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
        bus.d_md_use = 1'b0;
        exp_q.push_back({32'd0, 32'd21});
        run_op(MDU_MULT, 32'd3, 32'd7, 1'b0, cyc, stc, ist, early);
        total_cnt++; if ({ist, stc} !== 33'd0) $display("FAIL stall_no_use: got issue=%0b busy_stalls=%0d expected 0/0", ist, stc); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL stall_no_use_result: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int cyc, stc; logic ist, early;
        do_mt(MDU_MTHI, 32'h55);
        do_mt(MDU_MTLO, 32'h66);
        bus.start = 1'b1; bus.op = MDU_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %0b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL midreset_hilo: got %h expected 0", {bus.hi, bus.lo}); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        model_hilo = '0;
        @(negedge clk);
        exp_q.push_back({32'd0, 32'd42});
        run_op(MDU_MULT, 32'd6, 32'd7, 1'b0, cyc, stc, ist, early);
        total_cnt++; if (cyc !== 5) $display("FAIL postreset_busy_cycles: got %0d expected 5", cyc); else pass_cnt++;
        model_hilo = exp_q.pop_front();
        total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL postreset_result: got %h expected %h", {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, stc, exp_cyc; logic ist, early;
        logic [2:0] op; logic [31:0] a, b; logic [63:0] e;
        int sa, sb;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (op >= MDU_DIV) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (op == MDU_DIV && $urandom_range(0, 1) == 1) b = -b;
            sa = a; sb = b;
            case (op)
                MDU_MULT:  e = 64'(longint'($signed(a)) * longint'($signed(b)));
                MDU_MULTU: e = {32'd0, a} * {32'd0, b};
                MDU_DIV:   e = {32'(sa % sb), 32'(sa / sb)};
                default:   e = {a % b, a / b};
            endcase
            exp_cyc = (op >= MDU_DIV) ? 10 : 5;
            exp_q.push_back(e);
            run_op(op, a, b, 1'b0, cyc, stc, ist, early);
            total_cnt++; if (cyc !== exp_cyc) $display("FAIL b2b%0d_busy_cycles: got %0d expected %0d", i, cyc, exp_cyc); else pass_cnt++;
            model_hilo = exp_q.pop_front();
            total_cnt++; if ({bus.hi, bus.lo} !== model_hilo) $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {bus.hi, bus.lo}, model_hilo); else pass_cnt++;
        end
    endtask

    task automatic test_latency1();
        int cyc;
        bus1.start = 1'b1; bus1.op = MDU_MULT; bus1.rs = 32'd9; bus1.rt = 32'hFFFF_FFFF;
        @(negedge clk);
        bus1.start = 1'b0; bus1.op = MDU_NONE;
        cyc = 0;
        while (bus1.busy && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        total_cnt++; if (cyc !== 1) $display("FAIL lat1_busy_cycles: got %0d expected 1", cyc); else pass_cnt++;
        total_cnt++; if ({bus1.hi, bus1.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF7}) $display("FAIL lat1_result: got %h expected fffffffffffffff7", {bus1.hi, bus1.lo}); else pass_cnt++;
    endtask

    initial begin
        model_hilo = '0;
        @(negedge clk);
        test_reset();
        test_mt_and_mult();
        test_div();
        test_div0();
        test_cancel();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_latency1();
        total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
